// File: rtl/int_rob_pkg.sv
// rtl/int_rob_pkg.sv - shared sizes and entry record for the integer reorder buffer
// Purpose: default geometry, register-address width and the per-entry record
//          used by int_reorder_buffer and int_rob_lookup.
// Ports:   none (package).
package int_rob_pkg;

  localparam int ROB_DEPTH  = 8;
  localparam int ROB_TAG_W  = 3;
  localparam int ROB_DATA_W = 64;
  localparam int REG_ADDR_W = 5;

  typedef struct packed {
    logic                  valid;
    logic                  done;
    logic                  exc;
    logic                  wb;
    logic [REG_ADDR_W-1:0] dest;
    logic [ROB_DATA_W-1:0] data;
  } rob_entry_t;

endpackage

// File: rtl/int_rob_lookup.sv
// rtl/int_rob_lookup.sv - youngest in-flight producer search for one operand port
// Purpose: scans the entry array backwards from the tail and returns the
//          youngest valid, register-writing entry whose destination matches the
//          requested source register; otherwise falls back to the value that
//          is currently on the registered register-file write port.
// Ports:   i_entries  entry array of the reorder buffer
//          i_tail     allocation pointer (one past the youngest entry)
//          i_addr     source register to look up
//          i_wr_en / i_wr_addr / i_wr_data  registered register-file write port
//          o_hit      a producer exists
//          o_done     producer value is available
//          o_tag      producer entry tag
//          o_data     producer value (meaningful when o_done)
module int_rob_lookup
  import int_rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  rob_entry_t            i_entries [DEPTH],
  input  logic [TAG_W-1:0]      i_tail,
  input  logic [REG_ADDR_W-1:0] i_addr,
  input  logic                  i_wr_en,
  input  logic [REG_ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic                  o_hit,
  output logic                  o_done,
  output logic [TAG_W-1:0]      o_tag,
  output logic [DATA_W-1:0]     o_data
);

  logic             w_found;
  logic [TAG_W-1:0] w_idx;
  logic [DEPTH-1:0] w_unused_exc;

  // Exception state is irrelevant to forwarding; an excepted head flushes
  // everything before any consumer could use the value.
  for (genvar g = 0; g < DEPTH; g++) begin : g_unused
    assign w_unused_exc[g] = i_entries[g].exc;
  end

  always_comb begin
    o_hit   = 1'b0;
    o_done  = 1'b0;
    o_tag   = '0;
    o_data  = '0;
    w_found = 1'b0;
    w_idx   = '0;
    // i = 1 is the youngest slot (tail - 1); i = DEPTH wraps to the tail
    // itself, which is the oldest slot when the buffer is full.
    for (int i = 1; i <= DEPTH; i++) begin
      w_idx = i_tail - TAG_W'(i);
      if (!w_found && i_entries[w_idx].valid && i_entries[w_idx].wb &&
          (i_entries[w_idx].dest == i_addr)) begin
        w_found = 1'b1;
        o_hit   = 1'b1;
        o_done  = i_entries[w_idx].done;
        o_tag   = w_idx;
        o_data  = i_entries[w_idx].data[DATA_W-1:0];
      end
    end
    // The entry just committed has left the array but the register file has
    // not written it yet; forward from the write port for that one cycle.
    if (!w_found && i_wr_en && (i_wr_addr == i_addr)) begin
      o_hit  = 1'b1;
      o_done = 1'b1;
      o_data = i_wr_data;
    end
    if (i_addr == '0) begin
      o_hit  = 1'b0;
      o_done = 1'b0;
      o_tag  = '0;
      o_data = '0;
    end
  end

endmodule

// File: rtl/int_reorder_buffer.sv
// rtl/int_reorder_buffer.sv - in-order commit buffer in front of the 32x64 integer register file
// Purpose: allocates entries in program order, accepts out-of-order results,
//          commits the head entry to the register-file write port one per
//          cycle, flushes on an excepted head, and forwards in-flight results
//          to two dispatch operand lookup ports.
// Ports:   clock, reset (async, active-low), flush (sync discard-all)
//          alloc_valid/alloc_dest/alloc_wb in, alloc_ready/alloc_tag out
//          cmpl_valid/cmpl_tag/cmpl_data/cmpl_exc in
//          write_enable/write_addr/write_data out (registered regfile port)
//          exc_valid out (registered one-cycle pulse)
//          lookup_addr_a/b in; lookup_hit/done/tag/data_a/b out
module int_reorder_buffer
  import int_rob_pkg::*;
#(
  parameter int DEPTH  = ROB_DEPTH,
  parameter int TAG_W  = ROB_TAG_W,
  parameter int DATA_W = ROB_DATA_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  alloc_valid,
  input  logic [REG_ADDR_W-1:0] alloc_dest,
  input  logic                  alloc_wb,
  output logic                  alloc_ready,
  output logic [TAG_W-1:0]      alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [TAG_W-1:0]      cmpl_tag,
  input  logic [DATA_W-1:0]     cmpl_data,
  input  logic                  cmpl_exc,
  output logic                  write_enable,
  output logic [REG_ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0]     write_data,
  output logic                  exc_valid,
  input  logic [REG_ADDR_W-1:0] lookup_addr_a,
  input  logic [REG_ADDR_W-1:0] lookup_addr_b,
  output logic                  lookup_hit_a,
  output logic                  lookup_hit_b,
  output logic                  lookup_done_a,
  output logic                  lookup_done_b,
  output logic [TAG_W-1:0]      lookup_tag_a,
  output logic [TAG_W-1:0]      lookup_tag_b,
  output logic [DATA_W-1:0]     lookup_data_a,
  output logic [DATA_W-1:0]     lookup_data_b
);

  localparam int CNT_W = TAG_W + 1;

  rob_entry_t       r_entries [DEPTH];
  logic [TAG_W-1:0] r_head;
  logic [TAG_W-1:0] r_tail;
  logic [CNT_W-1:0] r_count;

  rob_entry_t w_head_entry;
  logic       w_full;
  logic       w_alloc;
  logic       w_commit;
  logic       w_commit_ok;
  logic       w_commit_exc;

  assign w_head_entry = r_entries[r_head];
  assign w_full       = (r_count == CNT_W'(DEPTH));
  assign alloc_ready  = !w_full;
  assign alloc_tag    = r_tail;
  // Readiness is taken from the pre-edge count, so a commit in the same
  // cycle never frees a slot for an allocation while full.
  assign w_alloc      = alloc_valid && !w_full;
  assign w_commit     = w_head_entry.valid && w_head_entry.done;
  assign w_commit_exc = w_commit && w_head_entry.exc;
  assign w_commit_ok  = w_commit && !w_head_entry.exc;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      write_enable <= 1'b0;
      write_addr   <= '0;
      write_data   <= '0;
      exc_valid    <= 1'b0;
    end else if (flush || w_commit_exc) begin
      // External flush and an excepted head both discard every entry,
      // including anything allocated or completed this cycle.
      for (int i = 0; i < DEPTH; i++) begin
        r_entries[i] <= '0;
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= '0;
      write_enable <= 1'b0;
      exc_valid    <= w_commit_exc && !flush;
    end else begin
      exc_valid    <= 1'b0;
      write_enable <= w_commit_ok && w_head_entry.wb && (w_head_entry.dest != '0);
      if (w_commit_ok) begin
        write_addr <= w_head_entry.dest;
        write_data <= w_head_entry.data[DATA_W-1:0];
      end

      if (cmpl_valid && r_entries[cmpl_tag].valid) begin
        r_entries[cmpl_tag].done <= 1'b1;
        r_entries[cmpl_tag].exc  <= cmpl_exc;
        r_entries[cmpl_tag].data <= ROB_DATA_W'(cmpl_data);
      end

      // Ordered after the completion update so a late completion to the
      // retiring head cannot resurrect it.
      if (w_commit_ok) begin
        r_entries[r_head] <= '0;
        r_head            <= r_head + 1'b1;
      end

      if (w_alloc) begin
        r_entries[r_tail] <= '{valid: 1'b1, done: 1'b0, exc: 1'b0, wb: alloc_wb,
                               dest: alloc_dest, data: '0};
        r_tail            <= r_tail + 1'b1;
      end

      r_count <= r_count + CNT_W'(w_alloc) - CNT_W'(w_commit_ok);
    end
  end

  int_rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lookup_a (
    .i_entries (r_entries),
    .i_tail    (r_tail),
    .i_addr    (lookup_addr_a),
    .i_wr_en   (write_enable),
    .i_wr_addr (write_addr),
    .i_wr_data (write_data),
    .o_hit     (lookup_hit_a),
    .o_done    (lookup_done_a),
    .o_tag     (lookup_tag_a),
    .o_data    (lookup_data_a)
  );

  int_rob_lookup #(.DEPTH(DEPTH), .TAG_W(TAG_W), .DATA_W(DATA_W)) u_lookup_b (
    .i_entries (r_entries),
    .i_tail    (r_tail),
    .i_addr    (lookup_addr_b),
    .i_wr_en   (write_enable),
    .i_wr_addr (write_addr),
    .i_wr_data (write_data),
    .o_hit     (lookup_hit_b),
    .o_done    (lookup_done_b),
    .o_tag     (lookup_tag_b),
    .o_data    (lookup_data_b)
  );

endmodule

// File: doc/int_reorder_buffer.md
Name: int_reorder_buffer

Overview:
- In-order commit buffer that sits directly upstream of the 32x64 integer register file.
- Dispatch allocates an entry per instruction in program order; execution units complete entries out of order; the head entry drives the register file write port (write_enable / write_addr / write_data), one commit per cycle.
- Provides two operand lookup ports so dispatch can take in-flight results before they reach the register file.

Parameters:
- DEPTH, 8, number of entries (power of two, ≥2).
- TAG_W, 3, log2(DEPTH); width of entry tags.
- DATA_W, 64, result width; matches the register file.

Ports:
- clock  in  1  system clock; state updates on posedge.
- reset  in  1  asynchronous, active-low.
- flush  in  1  synchronous; discard all entries.
- alloc_valid  in  1  dispatch requests an entry.
- alloc_dest  in  5  destination register.
- alloc_wb  in  1  instruction writes a register.
- alloc_ready  out  1  entry available (combinational, = !full).
- alloc_tag  out  TAG_W  tag of the entry being allocated (= tail pointer).
- cmpl_valid  in  1  execution result valid.
- cmpl_tag  in  TAG_W  completing entry.
- cmpl_data  in  DATA_W  result value.
- cmpl_exc  in  1  instruction raised an exception.
- write_enable  out  1  register file write enable (registered).
- write_addr  out  5  register file write address (registered).
- write_data  out  DATA_W  register file write data (registered).
- exc_valid  out  1  one-cycle pulse: the head instruction excepted (registered).
- lookup_addr_a, lookup_addr_b  in  5  source registers.
- lookup_hit_a/b  out  1  youngest in-flight producer exists.
- lookup_done_a/b  out  1  producer value is available.
- lookup_tag_a/b  out  TAG_W  producer tag.
- lookup_data_a/b  out  DATA_W  producer value, valid when done.

Behaviour:
- **Reset** (reset low, asynchronous):
  - head, tail and count clear to 0.
  - All valid/done/exc bits clear.
  - write_enable, write_addr, write_data and exc_valid clear to 0.
- **Allocate.** Occurs when alloc_valid && alloc_ready at a posedge:
  - entry[tail] gets valid=1, done=0, exc=0, dest, wb;
  - tail increments, wrapping modulo DEPTH.
  - alloc_ready is computed from the pre-edge count. When full, a same-cycle commit does not permit an allocation.
- **Complete.** Occurs when cmpl_valid at a posedge and entry[cmpl_tag].valid:
  - set done, data and exc.
  - A completion to an invalid entry is ignored.
  - A completion to an already-done entry overwrites it (not an error).
- **Commit.** Evaluated at each posedge on the pre-edge state; if entry[head] is valid and done:
  - Normal entry: head increments and the entry is cleared.
    - write_enable = wb && dest != 0.
    - write_addr = dest, write_data = data.
  - Excepted entry: write_enable = 0, exc_valid = 1, and all entries are flushed at the same edge. Allocations in that cycle are discarded.
  - Otherwise, write_enable = 0 and exc_valid = 0.
- **Latency.** Completion captured at edge N → commit outputs high after edge N+1 → register file writes at edge N+2.
  - Head completing in the same cycle it becomes head: done is registered, so commit happens at the next edge.
- **count** = count + alloc − commit. Simultaneous alloc and commit leave count unchanged.
- **flush.** At the posedge, clears all entries, head, tail and count.
  - Takes priority over alloc, complete and commit in that cycle.
  - write_enable and exc_valid go 0.
- **Lookup** (combinational, per port):
  - Search valid entries with wb=1 and dest == addr; select the youngest, i.e. nearest to tail going backwards.
  - If none match and the registered write_enable && write_addr == addr: hit=1, done=1, data = write_data (this covers the commit-to-regfile bubble).
  - addr 0 never hits.
- **Wrap-around.** Pointers wrap modulo DEPTH. Full is count == DEPTH; empty is count == 0.

Decomposition:
- Package int_rob_pkg:
  - DEPTH and TAG_W defaults.
  - Entry record: valid, done, exc, wb, dest[4:0], data[63:0].
  - Register address width constant, 5.
- Sub-module int_rob_lookup: combinational youngest-match priority search over the entry array. Instantiated twice, once per lookup port.

Test Plan:
- **Reset, allocate, complete.**
  - Stimulus: release reset; alloc dest=5 → tag 0; complete tag 0 with data 0x1234.
  - Response: write_enable=1, write_addr=5, write_data=0x1234 for exactly one cycle, one edge after completion.
- **Out-of-order completion.**
  - Stimulus: alloc dest 1,2,3; complete tags 2,1,0 on consecutive cycles.
  - Response: commits occur in order 1,2,3 on three consecutive cycles.
- **Full.**
  - Stimulus: 8 allocs without completion.
  - Response: alloc_ready=0 and alloc_tag=0 (wrapped).
  - Then complete tag 0: after the commit, alloc_ready=1 and the next alloc gets tag 0.
- **Exception.**
  - Stimulus: alloc 3 entries; complete tag 0 with cmpl_exc=1.
  - Response: exc_valid pulses once, write_enable stays 0, count becomes 0, the next alloc_tag is 0.
- **Lookup.**
  - Stimulus: alloc dest 7 (tag 0), alloc dest 7 (tag 1); lookup_addr_a=7.
  - Response: hit=1, tag=1, done=0. After tag 1 completes with 0xBEEF: done=1, data=0xBEEF. lookup 0 → hit=0.
- **flush and zero register.**
  - Stimulus: flush mid-stream.
  - Response: flush clears all entries with no write.
  - Stimulus: alloc dest 0 with wb=1, complete.
  - Response: the entry commits with write_enable=0.
